// File: rtl/dcpu_mem_arbiter.sv
// dcpu_mem_arbiter: single-port arbiter sharing the 64Kx16 main RAM between
// display fetch, CPU core and device DMA. One access per cycle, read data
// routed back one cycle later by a port tag, CPU bus lock for RMW sequences.
module dcpu_mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        disp_req,
  input  logic        disp_we,
  input  logic [15:0] disp_addr,
  input  logic [15:0] disp_wdata,
  output logic        disp_gnt,
  output logic        disp_rvalid,
  output logic [15:0] disp_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        hw_req,
  input  logic        hw_we,
  input  logic [15:0] hw_addr,
  input  logic [15:0] hw_wdata,
  output logic        hw_gnt,
  output logic        hw_rvalid,
  output logic [15:0] hw_rdata,
  input  logic        cpu_lock,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

  typedef enum logic [1:0] {ST_ARB, ST_LOCK, ST_RELEASE} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_CPU, TAG_HW} tag_t;

  state_t        state_q, state_d;
  tag_t          tag_q, tag_d;
  logic          rr_last_q, rr_last_d;   // 1 = hw was the last CPU/hw winner
  logic [SW-1:0] starve_q, starve_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [15:0]   addr_q, wdata_q;        // last issued command, held while idle

  // Grant selection: lock owner, forced CPU slot, display, then CPU/hw round-robin
  always_comb begin
    disp_gnt = 1'b0;
    cpu_gnt  = 1'b0;
    hw_gnt   = 1'b0;
    if (!RESET) begin
      case (state_q)
        ST_LOCK: cpu_gnt = cpu_req;
        ST_RELEASE: begin
          // CPU sits out exactly one slot after a maximal lock
          if (disp_req) disp_gnt = 1'b1;
          else          hw_gnt   = hw_req;
        end
        default: begin
          if (cpu_req && starve_q == STARVE_TOP) cpu_gnt  = 1'b1;
          else if (disp_req)                     disp_gnt = 1'b1;
          else if (cpu_req && (rr_last_q || !hw_req)) cpu_gnt = 1'b1;
          else                                   hw_gnt   = hw_req;
        end
      endcase
    end
  end

  // RAM command mux and read-return tag for the winning port
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    tag_d     = TAG_NONE;
    if (RESET) begin
      ram_addr  = 16'h0000;
      ram_wdata = 16'h0000;
    end else if (disp_gnt) begin
      ram_we    = disp_we;
      ram_addr  = disp_addr;
      ram_wdata = disp_wdata;
      tag_d     = disp_we ? TAG_NONE : TAG_DISP;
    end else if (cpu_gnt) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      tag_d     = cpu_we ? TAG_NONE : TAG_CPU;
    end else if (hw_gnt) begin
      ram_we    = hw_we;
      ram_addr  = hw_addr;
      ram_wdata = hw_wdata;
      tag_d     = hw_we ? TAG_NONE : TAG_HW;
    end
  end

  // Next-state for lock FSM, starvation counter and round-robin pointer
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    starve_d   = starve_q;
    rr_last_d  = rr_last_q;

    if (cpu_gnt || !cpu_req)                       starve_d = '0;
    else if (disp_gnt && starve_q != STARVE_TOP)   starve_d = starve_q + SW'(1);

    if (cpu_gnt)     rr_last_d = 1'b0;
    else if (hw_gnt) rr_last_d = 1'b1;

    case (state_q)
      ST_LOCK: begin
        if (!cpu_lock) begin
          state_d    = ST_ARB;
          lock_cnt_d = '0;
        end else if (cpu_gnt) begin
          lock_cnt_d = lock_cnt_q + LW'(1);
          if (lock_cnt_q + LW'(1) == LOCK_TOP) state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d    = ST_ARB;
        lock_cnt_d = '0;
      end
      default: begin
        state_d = ST_ARB;
        // The lock only begins once the CPU actually wins the bus
        if (cpu_gnt && cpu_lock) begin
          lock_cnt_d = LW'(1);
          state_d    = (LOCK_MAX <= 1) ? ST_RELEASE : ST_LOCK;
        end
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q    <= ST_ARB;
      tag_q      <= TAG_NONE;
      rr_last_q  <= 1'b1;
      starve_q   <= '0;
      lock_cnt_q <= '0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      rr_last_q  <= rr_last_d;
      starve_q   <= starve_d;
      lock_cnt_q <= lock_cnt_d;
      addr_q     <= ram_addr;
      wdata_q    <= ram_wdata;
    end
  end

  // Read return: shared data bus, per-port valid from the tag; reset squashes it
  assign disp_rvalid = !RESET && (tag_q == TAG_DISP);
  assign cpu_rvalid  = !RESET && (tag_q == TAG_CPU);
  assign hw_rvalid   = !RESET && (tag_q == TAG_HW);
  assign disp_rdata  = ram_rdata;
  assign cpu_rdata   = ram_rdata;
  assign hw_rdata    = ram_rdata;

endmodule

// File: tb/tb_dcpu_mem_arbiter.sv
// Randomized bench for dcpu_mem_arbiter with a transaction-level reference
// model (winner choice, memory image, read-return pipeline) plus directed cases.
module tb_dcpu_mem_arbiter;

  localparam int SL = 8;
  localparam int LM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_lock;
  logic        s_req [1:3];
  logic        s_we  [1:3];
  logic [15:0] s_addr[1:3];
  logic [15:0] s_wd  [1:3];

  logic        disp_gnt, disp_rvalid, cpu_gnt, cpu_rvalid, hw_gnt, hw_rvalid;
  logic [15:0] disp_rdata, cpu_rdata, hw_rdata;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we;

  dcpu_mem_arbiter #(.STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
    .CLOCK_50(clk), .RESET(rst),
    .disp_req(s_req[1]), .disp_we(s_we[1]), .disp_addr(s_addr[1]), .disp_wdata(s_wd[1]),
    .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .cpu_req(s_req[2]), .cpu_we(s_we[2]), .cpu_addr(s_addr[2]), .cpu_wdata(s_wd[2]),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .hw_req(s_req[3]), .hw_we(s_we[3]), .hw_addr(s_addr[3]), .hw_wdata(s_wd[3]),
    .hw_gnt(hw_gnt), .hw_rvalid(hw_rvalid), .hw_rdata(hw_rdata),
    .cpu_lock(cpu_lock),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM: write at the edge, registered read
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = normal, 1 = locked, 2 = one-slot release
  logic [15:0] ref_mem [0:65535];
  int          m_mode, m_starve, m_lockn, m_granted, m_rv_port;
  bit          m_last_hw;
  logic [15:0] m_last_addr, m_last_wd, m_rv_data;
  int          obs_gnt[$], obs_rv[$];
  logic [15:0] obs_rd[$];

  function automatic int model_winner();
    if (m_mode == 1) return s_req[2] ? 2 : 0;
    if (m_mode == 0 && m_starve >= SL && s_req[2]) return 2;
    if (s_req[1]) return 1;
    if (m_mode == 2) return s_req[3] ? 3 : 0;
    if (s_req[2] && s_req[3]) return m_last_hw ? 2 : 3;
    if (s_req[2]) return 2;
    if (s_req[3]) return 3;
    return 0;
  endfunction

  function automatic logic [2:0] onehot(input int p);
    return (p == 1) ? 3'b100 : (p == 2) ? 3'b010 : (p == 3) ? 3'b001 : 3'b000;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_starve = 0; m_lockn = 0; m_last_hw = 1'b1;
    m_last_addr = 16'h0; m_last_wd = 16'h0; m_rv_port = 0; m_granted = 0;
  endtask

  task automatic model_advance(input int w);
    if (w == 2 || !s_req[2]) m_starve = 0;
    else if (w == 1 && m_starve < SL) m_starve++;
    if (w == 2) m_last_hw = 1'b0;
    if (w == 3) m_last_hw = 1'b1;
    case (m_mode)
      0: if (w == 2 && cpu_lock) begin
           m_lockn = 1;
           m_mode  = (m_lockn >= LM) ? 2 : 1;
         end
      1: if (!cpu_lock) m_mode = 0;
         else if (w == 2) begin
           m_lockn++;
           if (m_lockn >= LM) m_mode = 2;
         end
      default: m_mode = 0;
    endcase
  endtask

  // Sampled on the falling edge: compare every output against the model
  task automatic check_cycle();
    logic [2:0] g;
    int w, o;
    g = {disp_gnt, cpu_gnt, hw_gnt};
    o = (g == 3'b100) ? 1 : (g == 3'b010) ? 2 : (g == 3'b001) ? 3 : (g == 3'b000) ? 0 : 4;
    obs_gnt.push_back(o);
    obs_rv.push_back(disp_rvalid ? 1 : cpu_rvalid ? 2 : hw_rvalid ? 3 : 0);
    obs_rd.push_back(ram_rdata);
    if (rst) begin
      chk("rst_gnt", g, 3'b000);
      chk("rst_we", ram_we, 1'b0);
      chk("rst_addr", ram_addr, 16'h0);
      chk("rst_wdata", ram_wdata, 16'h0);
      chk("rst_rvalid", {disp_rvalid, cpu_rvalid, hw_rvalid}, 3'b000);
      model_reset();
      return;
    end
    chk("rvalid", {disp_rvalid, cpu_rvalid, hw_rvalid}, onehot(m_rv_port));
    if (m_rv_port == 1) chk("disp_rdata", disp_rdata, m_rv_data);
    if (m_rv_port == 2) chk("cpu_rdata", cpu_rdata, m_rv_data);
    if (m_rv_port == 3) chk("hw_rdata", hw_rdata, m_rv_data);
    w = model_winner();
    chk("gnt", g, onehot(w));
    if (w != 0) begin
      chk("ram_we", ram_we, s_we[w]);
      chk("ram_addr", ram_addr, s_addr[w]);
      if (s_we[w]) chk("ram_wdata", ram_wdata, s_wd[w]);
      $display("txn t=%0t port=%0d %s addr=%h data=%h", $time, w,
               s_we[w] ? "WR" : "RD", s_addr[w], s_we[w] ? s_wd[w] : ref_mem[s_addr[w]]);
      m_last_addr = s_addr[w];
      m_rv_port   = s_we[w] ? 0 : w;
      m_rv_data   = ref_mem[s_addr[w]];
      if (s_we[w]) ref_mem[s_addr[w]] = s_wd[w];
    end else begin
      chk("idle_we", ram_we, 1'b0);
      chk("idle_addr", ram_addr, m_last_addr);
      m_rv_port = 0;
    end
    m_granted = w;
    model_advance(w);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  // Requesters keep their command until granted, then renew with a given rate
  task automatic update_stim(input int r1, input int r2, input int r3);
    int rt[1:3];
    rt = '{r1, r2, r3};
    for (int p = 1; p <= 3; p++) begin
      if (m_granted == p || !s_req[p]) begin
        s_req[p]  = (int'($urandom_range(0, 99)) < rt[p]);
        s_we[p]   = 1'($urandom_range(0, 1));
        s_addr[p] = 16'($urandom_range(0, 15));
        s_wd[p]   = 16'($urandom);
      end
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [15:0] a, input logic [15:0] d);
    s_req[p] = 1'b1; s_we[p] = we; s_addr[p] = a; s_wd[p] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_lock = 1'b0;
    for (int p = 1; p <= 3; p++) s_req[p] = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    obs_gnt.delete(); obs_rv.delete(); obs_rd.delete();
  endtask

  task automatic random_phase(input int n, input int r1, input int r2, input int r3,
                              input int lock_pct, input int rst_per_mil);
    for (int i = 0; i < n; i++) begin
      update_stim(r1, r2, r3);
      cpu_lock = (int'($urandom_range(0, 99)) < lock_pct);
      rst      = (int'($urandom_range(0, 999)) < rst_per_mil);
      cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_lock = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      s_req[p] = 1'b0; s_we[p] = 1'b0; s_addr[p] = 16'h0; s_wd[p] = 16'h0;
    end
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    mem[16'h1234] = 16'hBEEF;
    ref_mem[16'h1234] = 16'hBEEF;
    model_reset();

    // Reset values, then one idle cycle after release
    do_reset();
    cycle();
    chk("idle_after_rst", obs_gnt[0], 0);

    // Single CPU read of the preloaded word
    do_reset();
    set_req(2, 1'b0, 16'h1234, 16'h0);
    cycle();
    update_stim(0, 0, 0);
    cycle();
    chk("t1_gnt", obs_gnt[0], 2);
    chk("t1_rv", obs_rv[1], 2);
    chk("t1_rdata", obs_rd[1], 16'hBEEF);

    // CPU and hw contending: strict alternation, CPU first after reset
    do_reset();
    set_req(2, 1'b0, 16'h0003, 16'h0);
    set_req(3, 1'b0, 16'h0007, 16'h0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      update_stim(0, 100, 100);
    end
    for (int i = 0; i < 6; i++) chk($sformatf("t2_rr%0d", i), obs_gnt[i], (i % 2 == 0) ? 2 : 3);

    // Display hogging: CPU forced in every ninth slot
    do_reset();
    set_req(1, 1'b0, 16'h0001, 16'h0);
    set_req(2, 1'b0, 16'h0002, 16'h0);
    for (int i = 0; i < 18; i++) begin
      cycle();
      update_stim(100, 100, 0);
    end
    for (int i = 0; i < 18; i++) chk($sformatf("t3_starve%0d", i), obs_gnt[i], (i % 9 == 8) ? 2 : 1);

    // CPU lock: four locked grants, one release slot for display, CPU again
    do_reset();
    cpu_lock = 1'b1;
    set_req(2, 1'b0, 16'h0004, 16'h0);
    cycle();
    update_stim(0, 100, 0);
    set_req(1, 1'b0, 16'h0005, 16'h0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      update_stim(0, 100, 0);
    end
    for (int i = 0; i < 6; i++) chk($sformatf("t4_lock%0d", i), obs_gnt[i], (i == 4) ? 1 : 2);
    cpu_lock = 1'b0;

    // hw write followed immediately by a display read of the same word
    do_reset();
    set_req(3, 1'b1, 16'h8000, 16'h00FF);
    cycle();
    update_stim(0, 0, 0);
    set_req(1, 1'b0, 16'h8000, 16'h0);
    cycle();
    update_stim(0, 0, 0);
    cycle();
    chk("t5_wgnt", obs_gnt[0], 3);
    chk("t5_rgnt", obs_gnt[1], 1);
    chk("t5_rv", obs_rv[2], 1);
    chk("t5_rdata", obs_rd[2], 16'h00FF);

    // Reset in the cycle after a CPU read grant squashes the return
    do_reset();
    set_req(2, 1'b0, 16'h1234, 16'h0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_gnt", obs_gnt[0], 2);
    chk("t6_rv", obs_rv[1], 0);
    do_reset();

    // Randomized traffic against the reference model
    random_phase(800, 60, 60, 60, 30, 10);
    random_phase(300, 100, 100, 40, 0, 0);
    random_phase(400, 50, 100, 50, 85, 5);
    random_phase(200, 0, 90, 90, 50, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
